// File: rtl/mm_acc_collect_if.sv
`default_nettype none
// ============================================================================
//  Module      : mm_acc_collect_if
//  Description : Stream-in / result-out bundle for the dot-product collector.
//                The master side feeds products and consumes results; the
//                slave side is the collector itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface mm_acc_collect_if #(
  parameter int DW        = 8,
  parameter int N         = 10,
  parameter int RES_DEPTH = 4
);
  localparam int ACC_W = 2*DW + $clog2(N);
  localparam int FCNT_W = $clog2(RES_DEPTH) + 1;

  logic              clear;
  logic              in_valid;
  logic [2*DW-1:0]   in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic [FCNT_W-1:0] fifo_count;
  logic              busy;
  logic              overflow;
  logic              len_err;

  modport master (
    output clear, in_valid, in_data, in_last, out_ready,
    input  out_valid, out_data, fifo_count, busy, overflow, len_err
  );

  modport slave (
    input  clear, in_valid, in_data, in_last, out_ready,
    output out_valid, out_data, fifo_count, busy, overflow, len_err
  );
endinterface
`default_nettype wire

// File: rtl/mm_acc_collect.sv
`default_nettype none
// ============================================================================
//  Module      : mm_acc_collect
//  Description : Accumulates N unsigned products into one dot-product result
//                and queues finished results in a first-word-fall-through
//                FIFO with a valid/ready output.
//  Revision    : 1.0  initial release
// ============================================================================
module mm_acc_collect #(
  parameter int DW        = 8,
  parameter int N         = 10,
  parameter int RES_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  mm_acc_collect_if.slave  io_bus
);

  // Accumulator is sized so that N full-scale products can never wrap.
  localparam int ACC_W  = 2*DW + $clog2(N);
  localparam int ECNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PTR_W  = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [ECNT_W-1:0] c_LAST_IDX = ECNT_W'(N - 1);
  localparam logic [FCNT_W-1:0] c_FULL_CNT = FCNT_W'(RES_DEPTH);

  // --------------------------------------------------------------------------
  // Accumulator state
  // --------------------------------------------------------------------------
  logic [ACC_W-1:0]  r_acc;
  logic [ECNT_W-1:0] r_elem_cnt;

  // --------------------------------------------------------------------------
  // Result FIFO state
  // --------------------------------------------------------------------------
  logic [ACC_W-1:0]  r_mem [RES_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [FCNT_W-1:0] r_count;
  logic              r_out_valid;

  // Sticky status flags
  logic r_overflow;
  logic r_len_err;

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic              w_last_idx;
  logic [ACC_W-1:0]  w_acc_base;
  logic [ACC_W-1:0]  w_sum;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_wr_en;
  logic              w_drop;
  logic              w_len_bad;
  logic [FCNT_W-1:0] w_count_nxt;

  // The current beat completes a vector when the counter sits on N-1.
  assign w_last_idx = (r_elem_cnt == c_LAST_IDX);

  // First beat of a vector starts from zero, so a finished sum never needs
  // an explicit reset of r_acc between vectors.
  assign w_acc_base = (r_elem_cnt == '0) ? '0 : r_acc;
  assign w_sum      = w_acc_base + ACC_W'(io_bus.in_data);

  // Clear has priority inside the sequential blocks, so these strobes need
  // not qualify with it.
  assign w_push    = io_bus.in_valid && w_last_idx;
  assign w_pop     = r_out_valid && io_bus.out_ready;
  assign w_full    = (r_count == c_FULL_CNT);
  // A simultaneous pop frees the head slot, so a full FIFO can still accept.
  assign w_wr_en   = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;
  // in_last is only meaningful on a valid beat.
  assign w_len_bad = io_bus.in_valid && (io_bus.in_last != w_last_idx);

  // Next occupancy from the accepted write and the pop.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_en, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Accumulate valid beats and step the element counter modulo N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_elem_cnt <= '0;
    end else if (io_bus.clear) begin
      r_acc      <= '0;
      r_elem_cnt <= '0;
    end else if (io_bus.in_valid) begin
      r_acc      <= w_sum;
      r_elem_cnt <= w_last_idx ? '0 : r_elem_cnt + 1'b1;
    end
  end

  // FIFO pointers, occupancy and registered valid; storage written on push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < RES_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (io_bus.clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= w_sum;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != '0);
    end
  end

  // Sticky error flags; only reset or clear drops them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_len_err  <= 1'b0;
    end else if (io_bus.clear) begin
      r_overflow <= 1'b0;
      r_len_err  <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_len_bad) begin
        r_len_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign io_bus.out_valid  = r_out_valid;
  assign io_bus.out_data   = r_mem[r_rd_ptr];
  assign io_bus.fifo_count = r_count;
  assign io_bus.busy       = (r_elem_cnt != '0);
  assign io_bus.overflow   = r_overflow;
  assign io_bus.len_err    = r_len_err;

endmodule
`default_nettype wire
